// File: rtl/instr_encode_pkg.sv
// Shared definitions for the RV32I instruction encoder: opcodes, type_i bit
// positions and the output-register FSM states.
package instr_encode_pkg;

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam int T_R_TYPE = 0;
  localparam int T_LOAD   = 1;
  localparam int T_STORE  = 2;
  localparam int T_BRANCH = 3;
  localparam int T_I_TYPE = 4;
  localparam int T_JALR   = 5;
  localparam int T_JAL    = 6;
  localparam int T_LUI    = 7;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/instr_pack.sv
// Purely combinational RV32I word assembly from a one-hot class and raw fields.
// err_o flags a class vector that is not exactly one-hot; the word is then zero.
module instr_pack
  import instr_encode_pkg::*;
(
  input  logic [7:0]  type_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] instr_o,
  output logic        err_o
);

  logic one_hot;

  // x & (x-1) clears the lowest set bit, so a zero result means at most one bit.
  assign one_hot = (type_i != 8'd0) && ((type_i & (type_i - 8'd1)) == 8'd0);

  always_comb begin
    instr_o = 32'd0;
    err_o   = !one_hot;
    if (one_hot) begin
      if (type_i[T_R_TYPE]) begin
        instr_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OP_R_TYPE};
      end else if (type_i[T_LOAD]) begin
        instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_LOAD};
      end else if (type_i[T_STORE]) begin
        instr_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OP_STORE};
      end else if (type_i[T_BRANCH]) begin
        instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                   imm_i[4:1], imm_i[11], OP_BRANCH};
      end else if (type_i[T_I_TYPE]) begin
        instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_I_TYPE};
      end else if (type_i[T_JALR]) begin
        instr_o = {imm_i[11:0], rs1_i, 3'b000, rd_i, OP_JALR};
      end else if (type_i[T_JAL]) begin
        instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OP_JAL};
      end else begin
        instr_o = {imm_i[31:12], rd_i, OP_LUI};
      end
    end
  end

endmodule

// File: rtl/instr_encode.sv
// Registered RV32I encoder with valid/ready on both sides, a one-deep output
// register, a malformed-request pulse and a saturating emitted-word counter.
module instr_encode
  import instr_encode_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [7:0]       type_i,
  input  logic [4:0]       rd_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  input  logic [2:0]       funct3_i,
  input  logic [6:0]       funct7_i,
  input  logic [31:0]      imm_i,
  output logic [31:0]      instr_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             err_o,
  output logic [CNT_W-1:0] count_o
);

  state_t      state;
  state_t      next_state;
  logic [31:0] pack_word;
  logic        pack_err;
  logic        accept;
  logic        good_req;
  logic        bad_req;
  logic        word_xfer;

  instr_pack u_pack (
    .type_i   (type_i),
    .rd_i     (rd_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .funct3_i (funct3_i),
    .funct7_i (funct7_i),
    .imm_i    (imm_i),
    .instr_o  (pack_word),
    .err_o    (pack_err)
  );

  // ready_o depends only on registered state and ready_i, never on valid_i.
  assign valid_o = (state == ST_FULL);
  assign ready_o = !valid_o || ready_i;

  always_comb begin
    accept     = valid_i && ready_o;
    good_req   = accept && !pack_err;
    bad_req    = accept && pack_err;
    word_xfer  = valid_o && ready_i;
    next_state = state;
    case (state)
      ST_EMPTY: if (good_req) next_state = ST_FULL;
      ST_FULL:  if (word_xfer && !good_req) next_state = ST_EMPTY;
      default:  next_state = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_EMPTY;
      instr_o <= 32'd0;
      err_o   <= 1'b0;
      count_o <= '0;
    end else begin
      state <= next_state;
      err_o <= bad_req;
      if (good_req) begin
        instr_o <= pack_word;
      end
      if (word_xfer && (count_o != {CNT_W{1'b1}})) begin
        count_o <= count_o + CNT_W'(1);
      end
    end
  end

endmodule
